// File: rtl/wire_alu_pkg.sv
// Shared definitions for the wire-in ALU bank.
//   mode_e  : operation selected by the host (ADD, SUB, ACC, CLR)
//   state_e : bank sequencer states
//   clog2   : index width helper, never returns less than 1
package wire_alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // A one-channel bank still needs a 1-bit index register.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/wire_alu_bank_if.sv
// Host-side bundle of the ALU bank: wire-in operands/controls, trigger-in start,
// wire-out results/flags and trigger-out done.
//   master : host / endpoint side (drives start, mode, sat_en, chan_mask, op_a, op_b)
//   slave  : bank side (drives result, ovf, busy, done, collide)
interface wire_alu_bank_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [1:0]           mode;
  logic                 sat_en;
  logic [NCH-1:0]       chan_mask;
  logic [NCH*WIDTH-1:0] op_a;
  logic [NCH*WIDTH-1:0] op_b;
  logic [NCH*WIDTH-1:0] result;
  logic [NCH-1:0]       ovf;
  logic                 busy;
  logic                 done;
  logic                 collide;

  modport master (
    output start, mode, sat_en, chan_mask, op_a, op_b,
    input  result, ovf, busy, done, collide
  );

  modport slave (
    input  start, mode, sat_en, chan_mask, op_a, op_b,
    output result, ovf, busy, done, collide
  );
endinterface

// File: rtl/wire_alu_core.sv
// Combinational arithmetic unit shared by all channels of the bank.
//   mode_i   : operation select
//   sat_en_i : 1 = clamp on overflow/borrow, 0 = wrap
//   a_i/b_i  : operands; acc_i is the channel's current result (ACC only)
//   y_o      : result, ovf_o : carry/borrow out (reported even when wrapping)
module wire_alu_core
  import wire_alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  mode_e             mode_i,
  input  logic              sat_en_i,
  input  logic [Width-1:0]  a_i,
  input  logic [Width-1:0]  b_i,
  input  logic [Width-1:0]  acc_i,
  output logic [Width-1:0]  y_o,
  output logic              ovf_o
);

  logic [Width:0] s;

  always_comb begin
    s     = '0;
    y_o   = '0;
    ovf_o = 1'b0;
    unique case (mode_i)
      MODE_ADD: begin
        s     = {1'b0, a_i} + {1'b0, b_i};
        ovf_o = s[Width];
        y_o   = (ovf_o && sat_en_i) ? '1 : s[Width-1:0];
      end
      MODE_SUB: begin
        // MSB of the extended difference is the borrow (a < b).
        s     = {1'b0, a_i} - {1'b0, b_i};
        ovf_o = s[Width];
        y_o   = (ovf_o && sat_en_i) ? '0 : s[Width-1:0];
      end
      MODE_ACC: begin
        s     = {1'b0, acc_i} + {1'b0, a_i};
        ovf_o = s[Width];
        y_o   = (ovf_o && sat_en_i) ? '1 : s[Width-1:0];
      end
      MODE_CLR: begin
        y_o   = '0;
        ovf_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/wire_alu_bank.sv
// NCH-channel ALU bank: on a start trigger the operands and controls are
// snapshotted, then one channel per cycle is pushed through a single shared
// wire_alu_core. Latency start->done is always NCH+1 cycles.
//   okClk, reset : clock and synchronous active-high reset
//   bus (slave)  : start/mode/sat_en/chan_mask/op_a/op_b in,
//                  result/ovf/busy/done/collide out (all registered)
module wire_alu_bank
  import wire_alu_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic             okClk,
  input logic             reset,
  wire_alu_bank_if.slave  bus
);

  localparam int unsigned     IdxW    = clog2(NCH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  mode_e            mode_q;
  logic             sat_q;
  logic [NCH-1:0]   mask_q;
  logic [WIDTH-1:0] a_q   [NCH];
  logic [WIDTH-1:0] b_q   [NCH];
  logic [WIDTH-1:0] res_q [NCH];
  logic [NCH-1:0]   ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             collide_q;

  logic [WIDTH-1:0] core_y;
  logic             core_ovf;

  wire_alu_core #(
    .Width (WIDTH)
  ) u_core (
    .mode_i   (mode_q),
    .sat_en_i (sat_q),
    .a_i      (a_q[idx_q]),
    .b_i      (b_q[idx_q]),
    .acc_i    (res_q[idx_q]),
    .y_o      (core_y),
    .ovf_o    (core_ovf)
  );

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= MODE_ADD;
      sat_q     <= 1'b0;
      mask_q    <= '0;
      ovf_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      collide_q <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q <= mode_e'(bus.mode);
            sat_q  <= bus.sat_en;
            mask_q <= bus.chan_mask;
            for (int k = 0; k < NCH; k++) begin
              a_q[k] <= bus.op_a[k*WIDTH +: WIDTH];
              b_q[k] <= bus.op_b[k*WIDTH +: WIDTH];
            end
            collide_q <= 1'b0;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.start) begin
            collide_q <= 1'b1;
          end
          // Masked-out channels still consume their slot to keep latency fixed.
          if (mask_q[idx_q]) begin
            res_q[idx_q] <= core_y;
            ovf_q[idx_q] <= core_ovf;
          end
          if (idx_q == LastIdx) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.result = '0;
    for (int k = 0; k < NCH; k++) begin
      bus.result[k*WIDTH +: WIDTH] = res_q[k];
    end
  end

  assign bus.ovf     = ovf_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.collide = collide_q;

endmodule

// File: doc/wire_alu_bank.md
Name: wire_alu_bank

Overview:
- Parametrised successor of the single wire-in adder. Host supplies NCH operand pairs over wire-ins and issues a start trigger.
- The bank processes channels serially through one shared arithmetic unit and holds per-channel results and overflow flags for wire-outs.
- It emits a one-cycle done pulse for a trigger-out.
- Sits in the okClk domain between okWireIn/okTriggerIn endpoints and okWireOut/okTriggerOut endpoints in the top level. It contains no okHE/okEH bus logic.

Parameters:
NCH, 4, number of channels (1..16)
WIDTH, 32, operand/result width in bits (8..32)

Ports:
okClk  input  1  host-interface clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle trigger pulse requesting an operation
mode  input  2  0=ADD (a+b), 1=SUB (a-b), 2=ACC (result+a), 3=CLR
sat_en  input  1  1=saturate on overflow, 0=wrap modulo 2^WIDTH
chan_mask  input  NCH  1=process channel k; 0=leave result/ovf of k untouched
op_a  input  NCH*WIDTH  channel k operand A at [k*WIDTH +: WIDTH]
op_b  input  NCH*WIDTH  channel k operand B, same packing
result  output  NCH*WIDTH  registered per-channel results, same packing
ovf  output  NCH  per-channel overflow/borrow flag from last processing
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when an operation completes
collide  output  1  sticky: a start arrived while busy; cleared by reset or accepted start

Behaviour:
- Reset (synchronous, any state, including mid-RUN):
  - result, ovf, busy, done and collide go to 0; state goes to IDLE.
  - An aborted operation produces no done pulse. Partially written channels are zeroed.
- States: IDLE, RUN.
- IDLE, start=1 (accept in cycle T):
  - Snapshot mode, sat_en, chan_mask, op_a and op_b into shadow registers.
  - Clear collide. Set idx=0, busy=1, go to RUN.
  - Later changes to the inputs do not affect this operation.
- RUN, cycle T+1+k (k=0..NCH-1): channel k is processed.
  - If mask[k]=1: result[k] and ovf[k] load at the end of the cycle.
  - If mask[k]=0: both hold. The cycle is still spent, so latency is fixed.
- Completion: after the final channel (idx=NCH-1), go to IDLE with busy=0 and done=1 in cycle T+NCH+1. done is 1 for exactly one cycle.
- Total latency is start to done = NCH+1 cycles, independent of mask.
- start while busy (RUN):
  - Ignored and collide set to 1.
  - start coincident with the done cycle is accepted, because the state is already IDLE.
- Arithmetic (unsigned, WIDTH+1-bit intermediate):
  - ADD: s=a+b, ovf=carry. Saturated result = all-ones.
  - SUB: s=a-b, ovf=borrow (a<b). Saturated result = 0.
  - ACC: s=result[k]+a, ovf=carry. Saturated result = all-ones. op_b is ignored.
  - CLR: result[k]=0, ovf[k]=0 for masked-in channels.
  - sat_en=0: result = low WIDTH bits (wrap); ovf is still reported.
- ACC reads the current registered result[k], so repeated starts accumulate.
- An all-zero mask still runs NCH cycles and pulses done with no state change.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package wire_alu_pkg holds:
  - mode encodings MODE_ADD/SUB/ACC/CLR
  - state encoding ST_IDLE/ST_RUN
  - function clog2 for idx width
- Sub-module wire_alu_core: combinational WIDTH-parameterised unit.
  - Inputs: mode, sat_en, a, b, acc.
  - Outputs: y, ovf.
  - Instantiated once, shared across channels via idx mux.
- Top-level FSM, shadow registers and result array live in wire_alu_bank.

Test Plan:
- NCH=4, WIDTH=32. ADD, mask=4'hF, a={1,2,3,0xFFFFFFFF}, b={2,3,4,1}, sat_en=0 -> result={3,5,7,0}, ovf=4'b1000, done exactly 5 cycles after start, busy high 4 cycles.
- Same stimulus with sat_en=1 -> result[3]=0xFFFFFFFF, ovf[3]=1, others unchanged.
- SUB, a0=5, b0=7, mask=4'h1: sat_en=0 gives result0=0xFFFFFFFE with ovf0=1; sat_en=1 gives result0=0. Channels 1..3 hold prior values.
- CLR then three ACC starts with a0=0x10 -> result0=0x30 after the third done. start pulsed 2 cycles into a run -> ignored, collide=1, done count unchanged; next accepted start clears collide.
- reset asserted at cycle T+2 of a run -> next cycle all outputs 0, no done. start on the same cycle as done -> accepted, busy=1 next cycle, second done NCH+1 cycles later.
- Change op_a during RUN -> results reflect the snapshot taken at start. mask=0 -> done after 5 cycles, results unchanged.
